// File: rtl/seq_adder_nbit.sv
// seq_adder_nbit: multi-cycle WIDTH-bit adder/subtractor that processes CHUNK
// bits per clock. The carry (or borrow) is held between cycles.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits added per clock (WIDTH % CHUNK == 0); NCH = WIDTH/CHUNK RUN cycles
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request, sampled only in IDLE or DONE
//   sub             0 = add, 1 = subtract (captured with start)
//   inA, inB, cin   operands and carry/borrow-in (captured with start)
//   outS, cout, ovf registered result, carry/borrow-out, signed overflow
//   busy            high for the NCH RUN cycles
//   done            one-cycle pulse after completion
module seq_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic [WIDTH-1:0] outS,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("seq_adder_nbit: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;      // operand A, shifted right one chunk per cycle
  logic [WIDTH-1:0] b_r;      // operand B' (inverted in subtract mode), shifted likewise
  logic [WIDTH-1:0] sh;       // shadow sum, filled from the top one chunk per cycle
  logic             c_r;      // carry chain between chunks
  logic             mode;
  logic             a_msb;
  logic             b_msb;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] chunk_w;
  logic [WIDTH-1:0] sh_nx;
  logic             last;
  logic             accept;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(NCH - 1));

  // Datapath: the low chunk of the shifting operands is added each cycle. The
  // chunk sum enters the shadow register at the top, so after NCH cycles the
  // whole result is aligned in place.
  always_comb begin
    csum    = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + (CHUNK+1)'(c_r);
    chunk_w = WIDTH'(csum[CHUNK-1:0]);
    sh_nx   = (sh >> CHUNK) | (chunk_w << (WIDTH - CHUNK));
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sh    <= '0;
      c_r   <= 1'b0;
      mode  <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      outS  <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r   <= inA;
        b_r   <= sub ? ~inB : inB;
        c_r   <= sub ? ~cin : cin;
        mode  <= sub;
        a_msb <= inA[WIDTH-1];
        b_msb <= sub ? ~inB[WIDTH-1] : inB[WIDTH-1];
        cnt   <= '0;
        sh    <= '0;
      end else if (state == RUN) begin
        a_r <= a_r >> CHUNK;
        b_r <= b_r >> CHUNK;
        c_r <= csum[CHUNK];
        sh  <= sh_nx;
        cnt <= cnt + CW'(1);
        if (last) begin
          outS <= sh_nx;
          cout <= mode ? ~csum[CHUNK] : csum[CHUNK];
          // Same-sign operands producing an opposite-sign result is equivalent
          // to carry-into-MSB differing from carry-out-of-MSB.
          ovf  <= (a_msb == b_msb) && (sh_nx[WIDTH-1] != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Testbench for seq_adder_nbit: directed 8-bit vectors, handshake and reset
// sequences, plus an exhaustive 4-bit sweep for CHUNK = 1, 2 and 4.
module tb_seq_adder_nbit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance, CHUNK = 2
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, s8;
  logic       cout8, ovf8, busy8, done8;

  seq_adder_nbit #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .inA(a8), .inB(b8),
    .cin(cin8), .outS(s8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  // 4-bit instances, CHUNK = 1, 2, 4
  logic       sw_start[3], sw_sub[3], sw_cin[3];
  logic [3:0] sw_a[3], sw_b[3], sw_s[3];
  logic       sw_cout[3], sw_ovf[3], sw_busy[3], sw_done[3];

  seq_adder_nbit #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst(rst), .start(sw_start[0]), .sub(sw_sub[0]), .inA(sw_a[0]),
    .inB(sw_b[0]), .cin(sw_cin[0]), .outS(sw_s[0]), .cout(sw_cout[0]),
    .ovf(sw_ovf[0]), .busy(sw_busy[0]), .done(sw_done[0])
  );
  seq_adder_nbit #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
    .clk(clk), .rst(rst), .start(sw_start[1]), .sub(sw_sub[1]), .inA(sw_a[1]),
    .inB(sw_b[1]), .cin(sw_cin[1]), .outS(sw_s[1]), .cout(sw_cout[1]),
    .ovf(sw_ovf[1]), .busy(sw_busy[1]), .done(sw_done[1])
  );
  seq_adder_nbit #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
    .clk(clk), .rst(rst), .start(sw_start[2]), .sub(sw_sub[2]), .inA(sw_a[2]),
    .inB(sw_b[2]), .cin(sw_cin[2]), .outS(sw_s[2]), .cout(sw_cout[2]),
    .ovf(sw_ovf[2]), .busy(sw_busy[2]), .done(sw_done[2])
  );

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // busy and done must never be high together on any instance
  always @(negedge clk) begin
    if ((busy8 && done8) || (sw_busy[0] && sw_done[0]) ||
        (sw_busy[1] && sw_done[1]) || (sw_busy[2] && sw_done[2])) begin
      errs++;
      $display("FAIL busy_done_overlap at %0t", $time);
    end
  end

  // Issue one 8-bit operation; returns edges from the start edge to the edge
  // entering DONE (-1 on timeout) and the number of busy cycles seen.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic c, output int lat, output int bc);
    @(negedge clk);
    start8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    bc  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done8) begin
        lat = k - 1;
        break;
      end
      if (busy8) bc++;
      @(negedge clk);
    end
  endtask

  task automatic opw(input int i, input logic s, input logic [3:0] a,
                     input logic [3:0] b, input logic c, output int lat);
    @(negedge clk);
    sw_start[i] = 1'b1; sw_sub[i] = s; sw_a[i] = a; sw_b[i] = b; sw_cin[i] = c;
    @(negedge clk);
    sw_start[i] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (sw_done[i]) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Behavioural reference using plain integer arithmetic.
  function automatic void model(input int w, input int sb, input int a, input int b,
                                input int c, output int es, output int eco, output int eov);
    int m, full, sa, sbv, r;
    m = 1 << w;
    if (sb == 0) begin
      full = a + b + c;
      es   = full % m;
      eco  = full / m;
    end else begin
      full = a - b - c;
      es   = (full + 2 * m) % m;
      eco  = (a < b + c) ? 1 : 0;
    end
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    r   = (sb != 0) ? sa - sbv - c : sa + sbv + c;
    eov = (r < -(m / 2) || r > m / 2 - 1) ? 1 : 0;
  endfunction

  initial begin
    int lat, bc, es, eco, eov, t1, t2, k;
    int nchs[3];
    nchs = '{4, 2, 1};

    //           sub   a      b      cin   s      co    ov
    tbl[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    for (int i = 0; i < 3; i++) begin
      sw_start[i] = 1'b0; sw_sub[i] = 1'b0; sw_cin[i] = 1'b0;
      sw_a[i] = '0; sw_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_state8", {s8, cout8, ovf8, busy8, done8}, 32'h0);
    for (int i = 0; i < 3; i++)
      chk("reset_state4", {sw_s[i], sw_cout[i], sw_ovf[i], sw_busy[i], sw_done[i]}, 32'h0);
    rst = 1'b0;

    // Directed 8-bit vectors
    for (int i = 0; i < 9; i++) begin
      op8(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, lat, bc);
      chk($sformatf("tbl%0d_lat", i), lat, 4);
      chk($sformatf("tbl%0d_busy", i), bc, 4);
      chk($sformatf("tbl%0d_s", i), s8, tbl[i].s);
      chk($sformatf("tbl%0d_cout", i), cout8, tbl[i].co);
      chk($sformatf("tbl%0d_ovf", i), ovf8, tbl[i].ov);
    end

    // Start re-pulsed mid-RUN with other operands is ignored
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (k = 3; k <= 20; k++) begin
      if (done8) begin
        lat = k - 1;
        break;
      end
      @(negedge clk);
    end
    chk("ignore_lat", lat, 4);
    chk("ignore_s", s8, 8'h33);
    @(negedge clk);
    chk("ignore_idle_after", {busy8, done8}, 2'b00);

    // Start held through DONE: back-to-back ops, done pulses 5 cycles apart
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    t1 = -1; t2 = -1;
    for (k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin
        if (t1 < 0) begin
          t1 = k;
          chk("b2b_first_s", s8, 8'h03);
          a8 = 8'h03; b8 = 8'h04;
        end else begin
          t2 = k;
          chk("b2b_second_s", s8, 8'h07);
          start8 = 1'b0;
          break;
        end
      end
    end
    chk("b2b_spacing", t2 - t1, 5);
    start8 = 1'b0;

    // Asynchronous reset during RUN cycle 2
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    chk("pre_rst_outs", s8, 8'h07);
    @(negedge clk);
    chk("pre_rst_busy", busy8, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {s8, cout8, ovf8, busy8, done8}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op8(1'b0, 8'h10, 8'h20, 1'b0, lat, bc);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_s", s8, 8'h30);
    chk("post_rst_flags", {cout8, ovf8}, 2'b00);

    // Exhaustive 4-bit sweep against the reference model
    for (int i = 0; i < 3; i++)
      for (int sb = 0; sb < 2; sb++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
              opw(i, sb[0], a[3:0], b[3:0], c[0], lat);
              model(4, sb, a, b, c, es, eco, eov);
              chk($sformatf("sw_c%0d_lat", nchs[i] == 4 ? 1 : (nchs[i] == 2 ? 2 : 4)), lat, nchs[i]);
              if ({sw_s[i], sw_cout[i], sw_ovf[i]} !== {es[3:0], eco[0], eov[0]}) begin
                vecs++;
                errs++;
                $display("FAIL sweep inst%0d sub=%0d a=%0h b=%0h cin=%0d: got s=%0h co=%0b ov=%0b expected s=%0h co=%0d ov=%0d",
                         i, sb, a, b, c, sw_s[i], sw_cout[i], sw_ovf[i], es, eco, eov);
              end else begin
                vecs++;
              end
            end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
